serial_disp_rx: RTL and testbench

- Receiving end of the serial shift-out interface that the on-board display driver uses on `LED_CLK/LED_DO/LED_PEN` and `SEGLED_CLK/SEGLED_DO/SEGLED_PEN`.
- Oversamples the three serial lines on the system clock and reassembles each frame into a parallel word.
- Flags malformed frames.
- Used as a loopback checker in simulation and on-board, and as a decoder feeding the VGA debug overlay.

---
 rtl/serial_disp_rx.sv | 152 +++++++++++++++
 tb/tb_serial_disp_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_disp_rx.sv
// serial_disp_rx: receiver for the display driver's serial shift-out link.
// Oversamples s_clk/s_do/s_en on the system clock, reassembles each frame
// (MSB first) into a parallel word and flags frames with a wrong bit count.
module serial_disp_rx #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_clk,
    input  logic             s_do,
    input  logic             s_en,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Line order inside the synchronizer vectors: {s_en, s_do, s_clk}
    localparam logic [2:0] LINES_RST = 3'b100;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       meta_q, meta_d;
    logic [2:0]       sync_q, sync_d;
    logic [2:0]       hist_q, hist_d;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             clk_rise;
    logic             en_rise;
    logic             en_fall;
    logic             do_sync;
    logic [WIDTH-1:0] sh_next;
    logic [CNT_W-1:0] cnt_next;

    // Synchronizer and history next values
    always_comb begin
        meta_d = {s_en, s_do, s_clk};
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Synchronizer, history and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q       <= LINES_RST;
            sync_q       <= LINES_RST;
            hist_q       <= LINES_RST;
            sh_q         <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            hist_q       <= hist_d;
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Edge events from synchronized value vs. history; s_do taken from the
    // same stage as s_clk so the data bit lines up with its clock sample
    always_comb begin
        clk_rise = sync_q[0] & ~hist_q[0];
        en_fall  = ~sync_q[2] & hist_q[2];
        en_rise  = sync_q[2] & ~hist_q[2];
        do_sync  = sync_q[1];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_fall) state_d = SHIFT;
            SHIFT:   if (en_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift/count/close datapath; a clock rise coincident with the close is
    // folded into sh_d/cnt_d before the close decision reads them
    always_comb begin
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        sh_next      = {sh_q[WIDTH-2:0], do_sync};
        cnt_next     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        unique case (state_q)
            IDLE: begin
                if (en_fall) begin
                    sh_d  = '0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                if (clk_rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_next;
                end
                if (en_rise) begin
                    if (cnt_d == CNT_FULL) begin
                        data_d       = sh_d;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
            end
            default: begin
                sh_d  = '0;
                cnt_d = '0;
            end
        endcase
    end

    // FSM and registered outputs
    always_comb begin
        busy       = (state_q == SHIFT);
        data       = data_q;
        data_valid = data_valid_q;
        frame_err  = frame_err_q;
    end

endmodule

// File: tb/tb_serial_disp_rx.sv
// Bench for serial_disp_rx: a 16-bit and a 64-bit instance share the serial
// lines; sel gates s_en so only one of them sees a frame at a time.
module tb_serial_disp_rx;

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_clk = 1'b0;
    logic s_do = 1'b0;
    logic s_en = 1'b1;
    logic sel = 1'b0;
    logic en16, en64;

    logic [15:0] d16;
    logic        v16, e16, b16;
    logic [63:0] d64;
    logic        v64, e64, b64;
    logic        pv16 = 1'b0, pe16 = 1'b0, pv64 = 1'b0, pe64 = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    exp_t q16[$];
    exp_t q64[$];
    logic [15:0] good16 = '0;
    logic [63:0] good64 = '0;

    assign en16 = s_en | sel;
    assign en64 = s_en | ~sel;

    always #5 clk = ~clk;

    serial_disp_rx #(.WIDTH(16), .CNT_W(7)) dut16 (
        .clk(clk), .rst(rst), .s_clk(s_clk), .s_do(s_do), .s_en(en16),
        .data(d16), .data_valid(v16), .frame_err(e16), .busy(b16)
    );

    serial_disp_rx #(.WIDTH(64), .CNT_W(7)) dut64 (
        .clk(clk), .rst(rst), .s_clk(s_clk), .s_do(s_do), .s_en(en64),
        .data(d64), .data_valid(v64), .frame_err(e64), .busy(b64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic expect16(input logic err, input logic [15:0] w);
        exp_t x;
        x.err  = err;
        x.data = err ? {48'b0, good16} : {48'b0, w};
        q16.push_back(x);
        if (!err) good16 = w;
    endtask

    task automatic expect64(input logic err, input logic [63:0] w);
        exp_t x;
        x.err  = err;
        x.data = err ? good64 : w;
        q64.push_back(x);
        if (!err) good64 = w;
    endtask

    task automatic open_frame();
        s_clk = 1'b0;
        s_en  = 1'b0;
        cycles(3);
    endtask

    // Shift the low n bits of w MSB first; optionally raise s_en together
    // with the final s_clk rise
    task automatic shift_bits(input logic [63:0] w, input int unsigned n, input bit coincide);
        for (int unsigned i = 0; i < n; i++) begin
            s_do  = w[n-1-i];
            s_clk = 1'b0;
            cycles(3);
            if (coincide && (i == n - 1)) s_en = 1'b1;
            s_clk = 1'b1;
            cycles(3);
        end
        s_clk = 1'b0;
    endtask

    task automatic close_frame();
        s_clk = 1'b0;
        cycles(3);
        s_en = 1'b1;
    endtask

    // Scoreboard: every close pulse pops one expected result
    always @(negedge clk) begin
        exp_t x;
        if (v16 || e16) begin
            if (q16.size() == 0) begin
                check("unexpected_pulse16", {62'b0, v16, e16}, 64'd0);
            end else begin
                x = q16.pop_front();
                check("err16", {63'b0, e16}, {63'b0, x.err});
                check("valid16", {63'b0, v16}, {63'b0, ~x.err});
                check("data16", {48'b0, d16}, x.data);
            end
            check("pulse_width16", {63'b0, pv16 | pe16}, 64'd0);
        end
        if (v64 || e64) begin
            if (q64.size() == 0) begin
                check("unexpected_pulse64", {62'b0, v64, e64}, 64'd0);
            end else begin
                x = q64.pop_front();
                check("err64", {63'b0, e64}, {63'b0, x.err});
                check("valid64", {63'b0, v64}, {63'b0, ~x.err});
                check("data64", d64, x.data);
            end
            check("pulse_width64", {63'b0, pv64 | pe64}, 64'd0);
        end
        pv16 = v16; pe16 = e16; pv64 = v64; pe64 = e64;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat;
        cycles(4);
        check("rst_data16", {48'b0, d16}, 64'd0);
        check("rst_valid16", {63'b0, v16}, 64'd0);
        check("rst_err16", {63'b0, e16}, 64'd0);
        check("rst_busy16", {63'b0, b16}, 64'd0);
        check("rst_data64", d64, 64'd0);
        check("rst_busy64", {63'b0, b64}, 64'd0);
        rst = 1'b0;
        cycles(4);

        // Good frame with close latency measurement
        expect16(1'b0, 16'hA53C);
        open_frame();
        check("busy_open", {63'b0, b16}, 64'd1);
        shift_bits(64'hA53C, 16, 1'b0);
        close_frame();
        lat = 0;
        for (int unsigned k = 1; k <= 8; k++) begin
            @(negedge clk);
            if ((v16 || e16) && lat == 0) lat = k;
        end
        check("close_latency", 64'(lat), 64'd3);
        check("busy_after", {63'b0, b16}, 64'd0);

        // Short frame
        expect16(1'b1, 16'h0);
        open_frame();
        shift_bits(64'h1234, 15, 1'b0);
        close_frame();
        cycles(8);

        // Overlong frame
        expect16(1'b1, 16'h0);
        open_frame();
        shift_bits(64'h11234, 17, 1'b0);
        close_frame();
        cycles(8);
        check("cnt_sat", 64'(dut16.cnt_q), 64'd17);
        check("data_kept", {48'b0, d16}, 64'hA53C);

        // Last clock rise coincident with close
        expect16(1'b0, 16'hFFFF);
        open_frame();
        shift_bits(64'hFFFF, 16, 1'b1);
        cycles(8);

        // Reset mid-frame: discarded, close without open ignored
        open_frame();
        shift_bits(64'h00, 8, 1'b0);
        rst = 1'b1;
        cycles(3);
        check("midrst_busy", {63'b0, b16}, 64'd0);
        check("midrst_data", {48'b0, d16}, 64'd0);
        good16 = '0;
        rst  = 1'b0;
        s_en = 1'b1;
        cycles(10);
        check("postrst_data", {48'b0, d16}, 64'd0);
        check("postrst_busy", {63'b0, b16}, 64'd0);

        expect16(1'b0, 16'h8001);
        open_frame();
        shift_bits(64'h8001, 16, 1'b0);
        close_frame();
        cycles(8);

        // Back-to-back 64-bit frames with a 2-cycle s_en high gap
        sel = 1'b1;
        cycles(4);
        expect64(1'b0, 64'h0123456789ABCDEF);
        expect64(1'b0, 64'hFEDCBA9876543210);
        open_frame();
        shift_bits(64'h0123456789ABCDEF, 64, 1'b0);
        close_frame();
        cycles(2);
        open_frame();
        shift_bits(64'hFEDCBA9876543210, 64, 1'b0);
        close_frame();
        cycles(10);
        check("busy64_end", {63'b0, b64}, 64'd0);
        check("data64_end", d64, 64'hFEDCBA9876543210);

        check("pending16", 64'(q16.size()), 64'd0);
        check("pending64", 64'(q64.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
